// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and access-size encodings for the MIPS memory stage
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_if;
  import mips_pkg::*;
  logic              stall;
  logic              flush;
  logic              EX_MEM_memread;
  logic              EX_MEM_memwrite;
  logic              EX_MEM_memtoreg;
  logic              EX_MEM_regwrite;
  logic [REG_W-1:0]  EX_MEM_writereg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic              MEM_WB_memtoreg;
  logic              MEM_WB_regwrite;
  logic [REG_W-1:0]  MEM_WB_writereg;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] mem_alu_result;
  logic              addr_err;
  modport master (
    output stall, flush, EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_regwrite,
           EX_MEM_writereg, alu_result, store_data, mem_size, mem_unsigned,
    input  MEM_WB_memtoreg, MEM_WB_regwrite, MEM_WB_writereg, read_data, mem_alu_result, addr_err
  );
  modport slave (
    input  stall, flush, EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_regwrite,
           EX_MEM_writereg, alu_result, store_data, mem_size, mem_unsigned,
    output MEM_WB_memtoreg, MEM_WB_regwrite, MEM_WB_writereg, read_data, mem_alu_result, addr_err
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: single-port word RAM with byte-enable sync write and enabled registered read
module data_mem import mips_pkg::*; #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with fault detection and MEM/WB register; `SUBWORD_ACCESS_EN enables byte/half access
module mem_stage import mips_pkg::*; #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);
  logic              acc, oob, mis, fault, we, load_q;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata, rdata, ext;
  assign acc   = bus.EX_MEM_memread | bus.EX_MEM_memwrite;
  assign oob   = |bus.alu_result[DATA_W-1:ADDR_W+2];
  assign fault = (bus.EX_MEM_memread & bus.EX_MEM_memwrite) | (acc & (oob | mis));
  assign we    = rst_n & bus.EX_MEM_memwrite & ~fault & ~bus.stall & ~bus.flush;
`ifdef SUBWORD_ACCESS_EN
  logic [1:0] size_q, off_q;
  logic       uns_q;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  always_comb begin
    mis = bus.mem_size == SIZE_HALF ? bus.alu_result[0] :
          bus.mem_size == SIZE_WORD ? |bus.alu_result[1:0] : bus.mem_size != SIZE_BYTE;
    // big-endian lanes: byte offset 0 lives in bits 31:24
    be = bus.mem_size == SIZE_BYTE ? 4'b1000 >> bus.alu_result[1:0] :
         bus.mem_size == SIZE_HALF ? (bus.alu_result[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wdata = bus.mem_size == SIZE_BYTE ? {4{bus.store_data[7:0]}} :
            bus.mem_size == SIZE_HALF ? {2{bus.store_data[15:0]}} : bus.store_data;
    byte_v = rdata[(5'd24 - {off_q, 3'b000}) +: 8];
    half_v = off_q[1] ? rdata[15:0] : rdata[31:16];
    ext = size_q == SIZE_BYTE ? {{24{~uns_q & byte_v[7]}}, byte_v} :
          size_q == SIZE_HALF ? {{16{~uns_q & half_v[15]}}, half_v} : rdata;
  end
  always_ff @(posedge clk)
    if (!rst_n || bus.flush) {size_q, off_q, uns_q} <= '0;
    else if (!bus.stall) {size_q, off_q, uns_q} <= {bus.mem_size, bus.alu_result[1:0], bus.mem_unsigned};
`else
  always_comb begin
    mis = |bus.alu_result[1:0];
    be = 4'b1111;
    wdata = bus.store_data;
    ext = rdata;
  end
`endif
  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .we(we), .be(be), .addr(bus.alu_result[ADDR_W+1:2]),
    .wdata(wdata), .re(~bus.stall), .rdata(rdata)
  );
  assign bus.read_data = load_q ? ext : '0;
  always_ff @(posedge clk)
    if (!rst_n || bus.flush) begin
      bus.MEM_WB_memtoreg <= 1'b0;
      bus.MEM_WB_regwrite <= 1'b0;
      bus.MEM_WB_writereg <= '0;
      bus.mem_alu_result  <= '0;
      bus.addr_err        <= 1'b0;
      load_q              <= 1'b0;
    end else if (!bus.stall) begin
      bus.MEM_WB_memtoreg <= bus.EX_MEM_memtoreg;
      bus.MEM_WB_regwrite <= bus.EX_MEM_regwrite & ~fault;
      bus.MEM_WB_writereg <= bus.EX_MEM_writereg;
      bus.mem_alu_result  <= bus.alu_result;
      bus.addr_err        <= fault;
      load_q              <= bus.EX_MEM_memread & ~fault;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-addressed memory model
module tb_mem_stage;
  import mips_pkg::*;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem_b [DEPTH*4];
  logic [71:0] exp_q = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_stage_if bus();
  mem_stage #(.DEPTH(DEPTH), .ADDR_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [71:0] got();
    return {bus.MEM_WB_memtoreg, bus.MEM_WB_regwrite, bus.MEM_WB_writereg,
            bus.read_data, bus.mem_alu_result, bus.addr_err};
  endfunction

  task automatic drive(input logic rd, wr, m2r, rw, input logic [4:0] wreg, input logic [31:0] a, sd,
                       input logic [1:0] sz, input logic uns, st, fl, rn);
    int nb;
    logic bad, fault;
    logic [31:0] v;
    bus.EX_MEM_memread = rd; bus.EX_MEM_memwrite = wr; bus.EX_MEM_memtoreg = m2r;
    bus.EX_MEM_regwrite = rw; bus.EX_MEM_writereg = wreg; bus.alu_result = a;
    bus.store_data = sd; bus.mem_size = sz; bus.mem_unsigned = uns;
    bus.stall = st; bus.flush = fl; rst_n = rn;
    @(posedge clk);
    if (!rn || fl) exp_q = '0;
    else if (!st) begin
`ifdef SUBWORD_ACCESS_EN
      nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      bad = sz == 2'd3;
`else
      nb = 4;
      bad = 1'b0;
`endif
      fault = (rd && wr) || ((rd || wr) && (a >= DEPTH*4 || a % nb != 0 || bad));
      v = '0;
      if (rd && !fault) begin
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_b[a+i]);
        if (nb == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (nb == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
      end
      if (wr && !fault)
        for (int i = 0; i < nb; i++) mem_b[a+i] = 8'(sd >> (8*(nb-1-i)));
      exp_q = {m2r, rw & ~fault, wreg, v, a, fault};
    end
    #1;
  endtask

  task automatic op(input logic rd, wr, m2r, rw, input logic [4:0] wreg, input logic [31:0] a, sd,
                    input logic [1:0] sz, input logic uns);
    drive(rd, wr, m2r, rw, wreg, a, sd, sz, uns, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h40, 32'h0, SIZE_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (got() !== 72'h0) begin
        n_fail++; $display("FAIL reset: got %h expected 0", got());
      end
    end
  endtask

  task automatic test_store_load();
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0);
    n_chk++;
    if (got() !== exp_q) begin n_fail++; $display("FAIL sw: got %h expected %h", got(), exp_q); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (got() !== exp_q) begin n_fail++; $display("FAIL lw: got %h expected %h", got(), exp_q); end
    n_chk++;
    if (bus.read_data !== 32'hDEADBEEF || bus.MEM_WB_writereg !== 5'd8 || bus.addr_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_value: got %h/%0d/%b expected deadbeef/8/0",
                         bus.read_data, bus.MEM_WB_writereg, bus.addr_err);
    end
  endtask

  task automatic test_fault();
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.addr_err !== 1'b1 || bus.MEM_WB_regwrite !== 1'b0 || bus.read_data !== 32'h0) begin
      n_fail++; $display("FAIL misaligned_lw: got err=%b rw=%b rd=%h expected 1/0/0",
                         bus.addr_err, bus.MEM_WB_regwrite, bus.read_data);
    end
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, DEPTH*4, 32'h12345678, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oob_sw: got %b expected 1", bus.addr_err); end
    op(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h5, SIZE_WORD, 1'b0);
    n_chk++;
    if (got() !== exp_q) begin n_fail++; $display("FAIL rd_wr_both: got %h expected %h", got(), exp_q); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL oob_readback: got %h expected 0", bus.read_data); end
  endtask

  task automatic test_stall();
    logic [71:0] held;
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h30, 32'h0A0B0C0D, SIZE_WORD, 1'b0);
    held = got();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h30, 32'h55, SIZE_WORD, 1'b0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (got() !== held) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", got(), held); end
    end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h30, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'h0A0B0C0D) begin
      n_fail++; $display("FAIL stall_no_write: got %h expected 0a0b0c0d", bus.read_data);
    end
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h30, 32'h55, SIZE_WORD, 1'b0, 1'b1, 1'b0, 1'b1);
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h30, 32'h55, SIZE_WORD, 1'b0);
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h30, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'h55) begin n_fail++; $display("FAIL stall_release: got %h expected 55", bus.read_data); end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h30, 32'h77, SIZE_WORD, 1'b0, 1'b0, 1'b1, 1'b1);
    n_chk++;
    if (got() !== 72'h0) begin n_fail++; $display("FAIL flush_bubble: got %h expected 0", got()); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h30, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'h55) begin n_fail++; $display("FAIL flush_no_write: got %h expected 55", bus.read_data); end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'h0, SIZE_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (got() !== 72'h0) begin n_fail++; $display("FAIL midrun_reset: got %h expected 0", got()); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL midrun_mem_kept: got %h expected deadbeef", bus.read_data);
    end
  endtask

`ifdef SUBWORD_ACCESS_EN
  task automatic test_subword();
    logic [31:0] want [4];
    want = '{32'h11AA3344, 32'hFFFFFFAA, 32'h000000AA, 32'h00003344};
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11223344, SIZE_WORD, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h21, 32'h000000AA, SIZE_BYTE, 1'b0);
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h20, 32'h0, SIZE_WORD, 1'b0);
    n_chk++;
    if (bus.read_data !== want[0]) begin n_fail++; $display("FAIL sb_merge: got %h expected %h", bus.read_data, want[0]); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h21, 32'h0, SIZE_BYTE, 1'b0);
    n_chk++;
    if (bus.read_data !== want[1]) begin n_fail++; $display("FAIL lb: got %h expected %h", bus.read_data, want[1]); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h21, 32'h0, SIZE_BYTE, 1'b1);
    n_chk++;
    if (bus.read_data !== want[2]) begin n_fail++; $display("FAIL lbu: got %h expected %h", bus.read_data, want[2]); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h22, 32'h0, SIZE_HALF, 1'b0);
    n_chk++;
    if (bus.read_data !== want[3]) begin n_fail++; $display("FAIL lh: got %h expected %h", bus.read_data, want[3]); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h21, 32'h0, SIZE_HALF, 1'b0);
    n_chk++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL lh_misaligned: got %b expected 1", bus.addr_err); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h20, 32'h0, 2'b11, 1'b0);
    n_chk++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL size11: got %b expected 1", bus.addr_err); end
  endtask
`else
  task automatic test_word_only();
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11223344, SIZE_WORD, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h21, 32'h000000AA, SIZE_BYTE, 1'b0);
    n_chk++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL byte_rejected: got %b expected 1", bus.addr_err); end
    op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h20, 32'h0, SIZE_BYTE, 1'b0);
    n_chk++;
    if (bus.read_data !== 32'h11223344) begin
      n_fail++; $display("FAIL byte_no_write: got %h expected 11223344", bus.read_data);
    end
  endtask
`endif

  task automatic test_random();
    logic rd, wr;
    logic [31:0] a;
    int k, r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? $urandom : r == 1 ? DEPTH*4 + $urandom_range(0, 63) : $urandom_range(0, 255);
      k = $urandom_range(0, 9);
      rd = k <= 3 || k == 7;
      wr = (k >= 4 && k <= 6) || k == 7;
      drive(rd, wr, 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 49) != 0);
      n_chk++;
      if (got() !== exp_q) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", n, got(), exp_q); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h0;
    test_reset();
    test_store_load();
    test_fault();
    test_stall();
    test_flush();
    test_reset_midrun();
`ifdef SUBWORD_ACCESS_EN
    test_subword();
`else
    test_word_only();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
